// File: rtl/pe_stream_driver.sv
// pe_stream_driver
// Transmit-side sequencer feeding a single-PE Tile. Each accepted command
// emits one preload beat carrying the bias d. It then streams len operand
// pairs from a ready/valid queue, and finally idles for DRAIN_CYCLES so the PE
// pipeline flushes. The propagate bit toggles once per command.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   cmd_valid/ready     command handshake (ready decoded from state only)
//   cmd_len/shift/d     command length, shift and preload bias
//   op_valid/ready      operand handshake (ready decoded from state only)
//   op_a, op_b          activation / weight operand pair
//   out_a/b/d           registered Tile io_in_a_0 / io_in_b_0 / io_in_d_0
//   out_propagate       registered io_in_control_0_propagate
//   out_shift           registered io_in_control_0_shift
//   out_valid           registered io_in_valid_0
//   busy                registered, high whenever the FSM is not in IDLE
//   done                registered one-cycle pulse on command completion
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | cmd_ready=1; an accept loads the preload beat into out_* (PRELOAD)
// PRELOAD | not resident: the beat is loaded on the accept edge so that
//         | STREAM (or DRAIN when len=0) is already active one cycle later
// STREAM  | op_ready=1; each accepted pair becomes the next out_* beat
// DRAIN   | out_valid=0 for DRAIN_CYCLES, then IDLE with done=1
module pe_stream_driver #(
    parameter int DBITS        = 32,
    parameter int K_MAX        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_len,
    input  logic [4:0]       cmd_shift,
    input  logic [DBITS-1:0] cmd_d,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [18:0]      op_b,
    output logic [7:0]       out_a,
    output logic [18:0]      out_b,
    output logic [DBITS-1:0] out_d,
    output logic             out_propagate,
    output logic [4:0]       out_shift,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [4:0] K_MAX_L    = 5'(K_MAX);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [4:0]       len_q, len_d;
    logic [4:0]       beat_q, beat_d;
    logic [3:0]       drain_q, drain_d;
    logic [7:0]       out_a_q, out_a_d;
    logic [18:0]      out_b_q, out_b_d;
    logic [DBITS-1:0] out_d_q, out_d_d;
    logic             prop_q, prop_d;
    logic [4:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [4:0]       len_eff;
    logic [4:0]       beat_inc;

    assign len_eff  = (cmd_len > K_MAX_L) ? K_MAX_L : cmd_len;
    assign beat_inc = beat_q + 5'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            drain_q <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            out_d_q <= '0;
            prop_q  <= 1'b0;
            shift_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            out_d_q <= out_d_d;
            prop_q  <= prop_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        out_a_d = '0;
        out_b_d = '0;
        out_d_d = '0;
        prop_d  = prop_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d   = len_eff;
                    shift_d = cmd_shift;
                    prop_d  = ~prop_q;
                    beat_d  = '0;
                    valid_d = 1'b1;
                    out_d_d = cmd_d;
                    if (len_eff == 5'd0) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (op_valid) begin
                    valid_d = 1'b1;
                    out_a_d = op_a;
                    out_b_d = op_b;
                    beat_d  = beat_inc;
                    if (beat_inc == len_q) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                        beat_d  = '0;
                    end
                end
            end
            DRAIN: begin
                // Down-counter: terminal count 0 ends the drain window.
                if (drain_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cmd_ready     = (state_q == IDLE);
    assign op_ready      = (state_q == STREAM);
    assign out_a         = out_a_q;
    assign out_b         = out_b_q;
    assign out_d         = out_d_q;
    assign out_propagate = prop_q;
    assign out_shift     = shift_q;
    assign out_valid     = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed bench for pe_stream_driver (DBITS=32, K_MAX=16, DRAIN_CYCLES=2).
// Inputs change #1 after a rising edge; outputs are checked at that point.
// The operand source hands out pair n as (2n+1, 2n+2) and advances on every
// op_valid & op_ready handshake, counting consumed operands.
module tb_pe_stream_driver;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_len;
    logic [4:0]  cmd_shift;
    logic [31:0] cmd_d;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [18:0] op_b;
    logic [7:0]  out_a;
    logic [18:0] out_b;
    logic [31:0] out_d;
    logic        out_propagate;
    logic [4:0]  out_shift;
    logic        out_valid;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int op_idx = 0;
    int op_cnt = 0;

    pe_stream_driver #(
        .DBITS(32),
        .K_MAX(16),
        .DRAIN_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
        .cmd_shift(cmd_shift),
        .cmd_d(cmd_d),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_a(op_a),
        .op_b(op_b),
        .out_a(out_a),
        .out_b(out_b),
        .out_d(out_d),
        .out_propagate(out_propagate),
        .out_shift(out_shift),
        .out_valid(out_valid),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx);
        op_a = 8'(2 * idx + 1);
        op_b = 19'(2 * idx + 2);
    endtask

    task automatic tick();
        logic acc;
        acc = op_valid & op_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (acc) begin
            op_cnt++;
            op_idx++;
            set_op(op_idx);
        end
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic [7:0] a,
                            input logic [18:0] b, input logic [31:0] d,
                            input logic p, input logic [4:0] s);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".a"}, 64'(out_a), 64'(a));
        chk({tag, ".b"}, 64'(out_b), 64'(b));
        chk({tag, ".d"}, 64'(out_d), 64'(d));
        chk({tag, ".prop"}, 64'(out_propagate), 64'(p));
        chk({tag, ".shift"}, 64'(out_shift), 64'(s));
    endtask

    task automatic offer_cmd(input logic [4:0] len, input logic [4:0] sh, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_shift = sh;
        cmd_d     = d;
    endtask

    int base;
    int n;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_shift = '0;
        cmd_d     = '0;
        op_valid  = 1'b0;
        set_op(0);

        // ---- reset state --------------------------------------------------
        tick();
        tick();
        reset = 1'b0;
        chk_beat("rst", 1'b0, 8'd0, 19'd0, 32'd0, 1'b0, 5'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst.op_ready", 64'(op_ready), 64'd0);
        tick();
        tick();
        tick();

        // ---- T1: len=3 accepted at cycle 5, op_valid held high ------------
        op_idx = 0;
        set_op(0);
        op_valid = 1'b1;
        offer_cmd(5'd3, 5'd4, 32'h10);
        chk("t1.cyc_accept", 64'(cyc), 64'd5);
        chk("t1.idle_op_ready", 64'(op_ready), 64'd0);
        base = op_cnt;
        tick();
        cmd_valid = 1'b0;
        chk_beat("t1.pre@6", 1'b1, 8'd0, 19'd0, 32'h10, 1'b1, 5'd4);
        chk("t1.op_ready@6", 64'(op_ready), 64'd1);
        chk("t1.busy@6", 64'(busy), 64'd1);
        chk("t1.cmd_ready@6", 64'(cmd_ready), 64'd0);
        tick();
        chk_beat("t1.beat@7", 1'b1, 8'd1, 19'd2, 32'd0, 1'b1, 5'd4);
        tick();
        chk_beat("t1.beat@8", 1'b1, 8'd3, 19'd4, 32'd0, 1'b1, 5'd4);
        tick();
        chk_beat("t1.beat@9", 1'b1, 8'd5, 19'd6, 32'd0, 1'b1, 5'd4);
        chk("t1.op_ready@9", 64'(op_ready), 64'd0);
        tick();
        chk("t1.valid@10", 64'(out_valid), 64'd0);
        chk("t1.done@10", 64'(done), 64'd0);
        chk("t1.busy@10", 64'(busy), 64'd1);
        tick();
        chk("t1.cyc_done", 64'(cyc), 64'd11);
        chk("t1.done@11", 64'(done), 64'd1);
        chk("t1.busy@11", 64'(busy), 64'd0);
        chk("t1.cmd_ready@11", 64'(cmd_ready), 64'd1);
        chk("t1.shift@11", 64'(out_shift), 64'd4);
        chk("t1.prop@11", 64'(out_propagate), 64'd1);
        tick();
        chk("t1.done@12", 64'(done), 64'd0);
        chk("t1.consumed", 64'(op_cnt - base), 64'd3);

        // ---- T2: same command with a bubble in the 2nd STREAM cycle -------
        op_idx = 0;
        set_op(0);
        op_valid = 1'b1;
        offer_cmd(5'd3, 5'd4, 32'h10);
        base = op_cnt;
        tick();
        cmd_valid = 1'b0;
        chk_beat("t2.pre", 1'b1, 8'd0, 19'd0, 32'h10, 1'b0, 5'd4);
        tick();
        chk_beat("t2.beat1", 1'b1, 8'd1, 19'd2, 32'd0, 1'b0, 5'd4);
        op_valid = 1'b0;
        tick();
        chk_beat("t2.bubble", 1'b0, 8'd0, 19'd0, 32'd0, 1'b0, 5'd4);
        chk("t2.cnt_hold", 64'(op_cnt - base), 64'd1);
        chk("t2.op_ready_bubble", 64'(op_ready), 64'd1);
        op_valid = 1'b1;
        tick();
        chk_beat("t2.beat2", 1'b1, 8'd3, 19'd4, 32'd0, 1'b0, 5'd4);
        tick();
        chk_beat("t2.beat3", 1'b1, 8'd5, 19'd6, 32'd0, 1'b0, 5'd4);
        tick();
        chk("t2.valid_drain", 64'(out_valid), 64'd0);
        chk("t2.done_early", 64'(done), 64'd0);
        tick();
        chk("t2.done", 64'(done), 64'd1);
        chk("t2.consumed", 64'(op_cnt - base), 64'd3);
        tick();

        // ---- T3: back-to-back, second offered continuously ----------------
        op_idx = 0;
        set_op(0);
        op_valid = 1'b1;
        offer_cmd(5'd1, 5'd7, 32'h55);
        tick();
        chk_beat("t3.pre1", 1'b1, 8'd0, 19'd0, 32'h55, 1'b1, 5'd7);
        offer_cmd(5'd2, 5'd9, 32'hAA);
        tick();
        chk_beat("t3.beat1", 1'b1, 8'd1, 19'd2, 32'd0, 1'b1, 5'd7);
        tick();
        chk("t3.cmd_ready_drain", 64'(cmd_ready), 64'd0);
        tick();
        chk("t3.done1", 64'(done), 64'd1);
        chk("t3.cmd_ready_done", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk_beat("t3.pre2", 1'b1, 8'd0, 19'd0, 32'hAA, 1'b0, 5'd9);
        chk("t3.done_clear", 64'(done), 64'd0);
        tick();
        chk_beat("t3.beat2a", 1'b1, 8'd3, 19'd4, 32'd0, 1'b0, 5'd9);
        tick();
        chk_beat("t3.beat2b", 1'b1, 8'd5, 19'd6, 32'd0, 1'b0, 5'd9);
        tick();
        tick();
        chk("t3.done2", 64'(done), 64'd1);

        // ---- T4: len=0, op_valid held high throughout ----------------------
        base = op_cnt;
        offer_cmd(5'd0, 5'd3, 32'h1234);
        tick();
        cmd_valid = 1'b0;
        chk_beat("t4.pre", 1'b1, 8'd0, 19'd0, 32'h1234, 1'b1, 5'd3);
        chk("t4.op_ready_a", 64'(op_ready), 64'd0);
        chk("t4.busy", 64'(busy), 64'd1);
        tick();
        chk("t4.valid", 64'(out_valid), 64'd0);
        chk("t4.op_ready_b", 64'(op_ready), 64'd0);
        chk("t4.done_early", 64'(done), 64'd0);
        tick();
        chk("t4.done", 64'(done), 64'd1);
        chk("t4.consumed", 64'(op_cnt - base), 64'd0);
        tick();

        // ---- T5: len=20 clipped to K_MAX=16 --------------------------------
        op_idx = 0;
        set_op(0);
        base = op_cnt;
        offer_cmd(5'd20, 5'd1, 32'd0);
        tick();
        cmd_valid = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (op_cnt - base == 16 && out_valid) begin
                chk("t5.last_a", 64'(out_a), 64'd31);
                chk("t5.last_b", 64'(out_b), 64'd32);
            end
            tick();
            n++;
        end
        chk("t5.done_seen", 64'(done), 64'd1);
        chk("t5.cycles", 64'(n), 64'd19);
        chk("t5.consumed", 64'(op_cnt - base), 64'd16);
        tick();

        // ---- T6: reset after 2 of 5 operands -------------------------------
        op_idx = 0;
        set_op(0);
        base = op_cnt;
        offer_cmd(5'd5, 5'd6, 32'h77);
        tick();
        cmd_valid = 1'b0;
        chk("t6.pre_prop", 64'(out_propagate), 64'd1);
        tick();
        tick();
        chk("t6.two_taken", 64'(op_cnt - base), 64'd2);
        reset = 1'b1;
        op_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk_beat("t6.rst", 1'b0, 8'd0, 19'd0, 32'd0, 1'b0, 5'd0);
        chk("t6.busy", 64'(busy), 64'd0);
        chk("t6.done", 64'(done), 64'd0);
        chk("t6.cmd_ready", 64'(cmd_ready), 64'd1);
        op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6.no_done", 64'(done), 64'd0);
        end
        chk("t6.no_consume", 64'(op_cnt - base), 64'd2);
        op_idx = 0;
        set_op(0);
        offer_cmd(5'd1, 5'd2, 32'h99);
        tick();
        cmd_valid = 1'b0;
        chk_beat("t6.new_pre", 1'b1, 8'd0, 19'd0, 32'h99, 1'b1, 5'd2);
        tick();
        chk_beat("t6.new_beat", 1'b1, 8'd1, 19'd2, 32'd0, 1'b1, 5'd2);
        tick();
        tick();
        chk("t6.new_done", 64'(done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
